// File: rtl/pacman_move_ctrl.sv
// rtl/pacman_move_ctrl.sv - Pac-Man movement controller: step timing, turn buffer, lives and game states
module pacman_move_ctrl #(
   parameter int STEP_DIV    = 8,
   parameter int BUF_TICKS   = 4,
   parameter int NUM_LIVES   = 3,
   parameter int DEATH_TICKS = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       win,
   input  logic       lose,
   input  logic [3:0] en,
   input  logic [3:0] req,
   output logic [3:0] move,
   output logic [1:0] heading,
   output logic       e_start,
   output logic       m_hold,
   output logic       dying,
   output logic       game_won,
   output logic       game_over,
   output logic [2:0] lives
);
   localparam int DIV_W = $clog2(STEP_DIV);
   localparam int AGE_W = $clog2(BUF_TICKS + 1);
   localparam int DTH_W = $clog2(DEATH_TICKS + 1);
   localparam logic [1:0] DIR_L = 2'd3;

   typedef enum logic [2:0] {
      S_START,
      S_HOLD,
      S_MOVE,
      S_DYING,
      S_WIN,
      S_OVER
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [DTH_W-1:0] death_cnt;
   logic [AGE_W-1:0] buf_age;
   logic [1:0]       buf_dir;
   logic             buf_valid;
   logic             start_q;

   logic             active;
   logic             tick;
   logic             start_rise;
   logic             buf_hit;
   logic             head_open;
   logic [1:0]       req_dir;

   // Direction code 0..3 (U,D,R,L) maps onto the {U,D,R,L} bit vectors MSB first.
   function automatic logic [3:0] dir_onehot(input logic [1:0] d);
      dir_onehot = 4'b1000 >> d;
   endfunction

   always_comb begin
      req_dir = 2'd3;
      if (req[3])
         req_dir = 2'd0;
      else if (req[2])
         req_dir = 2'd1;
      else if (req[1])
         req_dir = 2'd2;
   end

   assign active     = (state == S_HOLD) || (state == S_MOVE) || (state == S_DYING);
   assign tick       = active && (div_cnt == DIV_W'(STEP_DIV - 1));
   assign start_rise = start & ~start_q;
   assign buf_hit    = buf_valid && (|(en & dir_onehot(buf_dir)));
   assign head_open  = |(en & dir_onehot(heading));

   assign e_start   = (state == S_START);
   assign m_hold    = (state == S_HOLD);
   assign dying     = (state == S_DYING);
   assign game_won  = (state == S_WIN);
   assign game_over = (state == S_OVER);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_START;
         heading   <= DIR_L;
         lives     <= 3'(NUM_LIVES);
         buf_dir   <= 2'd0;
         buf_valid <= 1'b0;
         buf_age   <= '0;
         div_cnt   <= '0;
         death_cnt <= '0;
         move      <= 4'b0000;
         start_q   <= 1'b0;
      end else begin
         start_q <= start;
         move    <= 4'b0000;

         if (active)
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         else
            div_cnt <= '0;

         case (state)
            S_START: begin
               buf_valid <= 1'b0;
               if (start_rise) begin
                  state   <= S_HOLD;
                  lives   <= 3'(NUM_LIVES);
                  heading <= DIR_L;
               end
            end

            S_HOLD, S_MOVE: begin
               if (lose) begin
                  state     <= S_DYING;
                  div_cnt   <= '0;
                  death_cnt <= '0;
                  buf_valid <= 1'b0;
                  if (lives != 3'd0)
                     lives <= lives - 3'd1;
               end else if (win) begin
                  state     <= S_WIN;
                  div_cnt   <= '0;
                  buf_valid <= 1'b0;
               end else begin
                  if (tick) begin
                     if (buf_hit) begin
                        heading   <= buf_dir;
                        move      <= dir_onehot(buf_dir);
                        buf_valid <= 1'b0;
                        if (state == S_HOLD) begin
                           state   <= S_MOVE;
                           div_cnt <= '0;
                        end
                     end else begin
                        if (buf_valid) begin
                           buf_age <= buf_age + AGE_W'(1);
                           if (buf_age == AGE_W'(BUF_TICKS - 1))
                              buf_valid <= 1'b0;
                        end
                        if (state == S_MOVE) begin
                           if (head_open)
                              move <= dir_onehot(heading);
                           else begin
                              state   <= S_HOLD;
                              div_cnt <= '0;
                           end
                        end
                     end
                  end
                  // The tick above used the old buffer; a press this cycle is latched afterwards.
                  if (|req) begin
                     buf_dir   <= req_dir;
                     buf_valid <= 1'b1;
                     buf_age   <= '0;
                  end
               end
            end

            S_DYING: begin
               if (tick) begin
                  if (death_cnt == DTH_W'(DEATH_TICKS - 1)) begin
                     death_cnt <= '0;
                     div_cnt   <= '0;
                     if (lives == 3'd0)
                        state <= S_OVER;
                     else begin
                        state   <= S_HOLD;
                        heading <= DIR_L;
                     end
                  end else begin
                     death_cnt <= death_cnt + DTH_W'(1);
                  end
               end
            end

            S_WIN, S_OVER: begin
               if (start_rise) begin
                  state     <= S_START;
                  buf_valid <= 1'b0;
               end
            end

            default: state <= S_START;
         endcase
      end
   end
endmodule

// File: tb/tb_pacman_move_ctrl.sv
// tb/tb_pacman_move_ctrl.sv - directed self-checking bench for pacman_move_ctrl
module tb_pacman_move_ctrl;
   logic       clk;
   logic       reset;
   logic       start;
   logic       win;
   logic       lose;
   logic [3:0] en;
   logic [3:0] req;
   logic [3:0] move;
   logic [1:0] heading;
   logic       e_start;
   logic       m_hold;
   logic       dying;
   logic       game_won;
   logic       game_over;
   logic [2:0] lives;

   int         total;
   int         bad;
   int         cnt;
   logic [3:0] orv;
   logic [3:0] mv;

   pacman_move_ctrl #(
      .STEP_DIV   (8),
      .BUF_TICKS  (4),
      .NUM_LIVES  (3),
      .DEATH_TICKS(6)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .win      (win),
      .lose     (lose),
      .en       (en),
      .req      (req),
      .move     (move),
      .heading  (heading),
      .e_start  (e_start),
      .m_hold   (m_hold),
      .dying    (dying),
      .game_won (game_won),
      .game_over(game_over),
      .lives    (lives)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++)
         @(negedge clk);
   endtask

   task automatic watch(input int n, output int c, output logic [3:0] o);
      c = 0;
      o = 4'b0000;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (move != 4'b0000)
            c++;
         o = o | move;
      end
   endtask

   task automatic wait_move(input int budget, output logic [3:0] m);
      m = 4'b0000;
      for (int i = 0; i < budget && m == 4'b0000; i++) begin
         @(negedge clk);
         m = move;
      end
   endtask

   task automatic press(input logic [3:0] r);
      req = r;
      step(1);
      req = 4'b0000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      start = 1'b0;
      win   = 1'b0;
      lose  = 1'b0;
      en    = 4'b0000;
      req   = 4'b0000;
      step(2);
      chk("rst_e_start", 32'(e_start), 1);
      chk("rst_m_hold", 32'(m_hold), 0);
      chk("rst_dying", 32'(dying), 0);
      chk("rst_won", 32'(game_won), 0);
      chk("rst_over", 32'(game_over), 0);
      chk("rst_lives", 32'(lives), 3);
      chk("rst_heading", 32'(heading), 3);
      chk("rst_move", 32'(move), 0);
      reset = 1'b1;
      step(2);
      chk("idle_e_start", 32'(e_start), 1);

      // start press: HOLD, no motion without a request
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("t1_e_start", 32'(e_start), 0);
      chk("t1_m_hold", 32'(m_hold), 1);
      chk("t1_lives", 32'(lives), 3);
      watch(40, cnt, orv);
      chk("t1_no_move", 32'(cnt), 0);
      chk("t1_still_hold", 32'(m_hold), 1);

      // HOLD -> MOVE left, steady pulses, then wall hit
      en = 4'b0011;
      press(4'b0001);
      wait_move(20, mv);
      chk("t2_first_mv", 32'(mv), 1);
      chk("t2_heading", 32'(heading), 3);
      chk("t2_not_hold", 32'(m_hold), 0);
      watch(32, cnt, orv);
      chk("t2_pulse_cnt", 32'(cnt), 4);
      chk("t2_pulse_dir", 32'(orv), 1);
      en = 4'b0010;
      watch(16, cnt, orv);
      chk("t2_wall_cnt", 32'(cnt), 0);
      chk("t2_wall_hold", 32'(m_hold), 1);

      // buffered turn: expired after 5 ticks, taken after 2 ticks
      en = 4'b0011;
      press(4'b0001);
      wait_move(20, mv);
      chk("t3_restart_mv", 32'(mv), 1);
      press(4'b1000);
      step(40);
      en = 4'b1011;
      watch(16, cnt, orv);
      chk("t3_exp_cnt", 32'(cnt), 2);
      chk("t3_exp_dir", 32'(orv), 1);
      chk("t3_exp_heading", 32'(heading), 3);
      en = 4'b0011;
      press(4'b1000);
      step(16);
      en = 4'b1011;
      watch(9, cnt, orv);
      chk("t3_turn_dir", 32'(orv), 8);
      chk("t3_turn_heading", 32'(heading), 0);

      // lose beats win; death sequence lasts 48 clocks
      lose = 1'b1;
      win  = 1'b1;
      step(1);
      lose = 1'b0;
      win  = 1'b0;
      chk("t4_dying", 32'(dying), 1);
      chk("t4_not_won", 32'(game_won), 0);
      chk("t4_lives", 32'(lives), 2);
      chk("t4_no_pulse", 32'(move), 0);
      step(47);
      chk("t4_still_dying", 32'(dying), 1);
      step(1);
      chk("t4_hold", 32'(m_hold), 1);
      chk("t4_heading", 32'(heading), 3);

      // run out of lives with start held high
      start = 1'b1;
      lose  = 1'b1;
      step(1);
      lose = 1'b0;
      chk("t5_lives1", 32'(lives), 1);
      step(48);
      chk("t5_hold1", 32'(m_hold), 1);
      lose = 1'b1;
      step(1);
      lose = 1'b0;
      chk("t5_lives0", 32'(lives), 0);
      chk("t5_dying", 32'(dying), 1);
      step(48);
      chk("t5_over", 32'(game_over), 1);
      chk("t5_over_lives", 32'(lives), 0);
      step(5);
      chk("t5_held_no_restart", 32'(game_over), 1);
      start = 1'b0;
      step(1);
      start = 1'b1;
      step(1);
      chk("t5_e_start", 32'(e_start), 1);
      start = 1'b0;
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("t5_hold_again", 32'(m_hold), 1);
      chk("t5_lives_reload", 32'(lives), 3);

      // asynchronous reset while a pulse is showing
      en = 4'b0011;
      press(4'b0001);
      wait_move(20, mv);
      chk("t6_mv_before", 32'(mv), 1);
      reset = 1'b0;
      #1;
      chk("t6_move_clr", 32'(move), 0);
      chk("t6_e_start", 32'(e_start), 1);
      chk("t6_lives", 32'(lives), 3);
      chk("t6_heading", 32'(heading), 3);
      @(negedge clk);
      reset = 1'b1;
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      watch(40, cnt, orv);
      chk("t6_buf_empty", 32'(cnt), 0);
      chk("t6_hold", 32'(m_hold), 1);

      // request priority, then win and restart
      en = 4'b1111;
      press(4'b1111);
      wait_move(20, mv);
      chk("t7_prio_mv", 32'(mv), 8);
      chk("t7_prio_heading", 32'(heading), 0);
      win = 1'b1;
      step(1);
      win = 1'b0;
      chk("t7_won", 32'(game_won), 1);
      chk("t7_won_move", 32'(move), 0);
      watch(16, cnt, orv);
      chk("t7_won_idle", 32'(cnt), 0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("t7_e_start", 32'(e_start), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
